scratchpad_mls_responder: RTL and testbench
===========================================

// Module: scratchpad_mls_responder
// PURPOSE
//  Scratchpad-side responder for the matrix load/store FU request (matrix_ls_t). Accepts one
//  M_LOAD/M_STORE request, moves ROWS rows between the memory port and the matrix register file
//  at address + r*stride, then returns a one-cycle done carrying md. Sits between MLS FU and DRAM.
// PARAMETERS
//  ROWS    4    rows per matrix (tensor tile height)
//  ELEM_W  16   bits per element
//  ROW_W   64   ROWS*ELEM_W, bits per row (memory/MRF data width)
// PORTS
//  CLK          in   1      clock
//  nRST         in   1      async active-low reset
//  mls_req      in   71     matrix_ls_t {done,ls_out,rd_out,address,stride_out}; valid = ls_out!=matrix_na
//  req_ready    out  1      request accepted on cycle where valid & req_ready
//  mem_req      out  1      memory access request, held until mem_ack
//  mem_wen      out  1      1 = write (store), 0 = read (load)
//  mem_addr     out  32     row byte address
//  mem_wdata    out  ROW_W  store data
//  mem_rdata    in   ROW_W  load data, valid with mem_ack
//  mem_ack      in   1      access complete this cycle
//  mrf_wen      out  1      matrix regfile row write
//  mrf_sel      out  4      matbits_t register (latched rd_out)
//  mrf_row      out  2      row index ($clog2(ROWS))
//  mrf_wdata    out  ROW_W  row write data
//  mrf_rdata    in   ROW_W  row read data, combinational from mrf_sel/mrf_row
//  resp_done    out  1      one-cycle completion pulse to MLS FU / writeback
//  resp_md      out  4      destination matrix of completed op (m_rw for RST clear)
//  resp_err     out  1      misaligned request (MLS_ALIGN_CHECK_EN only; else tied 0)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, row counter 0; async reset mid-transfer abandons it, no done.
//  FSM: IDLE -> (valid&ready) LOAD or STORE; LOAD/STORE -> (mem_ack & row==ROWS-1) DONE; DONE -> IDLE.
//  IDLE: req_ready=1; on accept latch ls_out, rd_out, address, stride; row=0; addr_cur=address.
//  LOAD: mem_req=1, mem_wen=0, mem_addr=addr_cur; on mem_ack: mrf_wen=1 same cycle, mrf_wdata=mem_rdata,
//   mrf_row=row; then row++, addr_cur+=stride.
//  STORE: mem_req=1, mem_wen=1, mrf_row=row, mem_wdata=mrf_rdata; on mem_ack row++, addr_cur+=stride.
//  DONE: resp_done=1, resp_md=latched rd_out for exactly one cycle; req_ready=0.
//  req_ready=0 in LOAD/STORE/DONE; requests presented while busy are held by the FU, not dropped.
//  Latency with mem_ack tied 1: accept edge T, rows on T+1..T+ROWS, resp_done in cycle T+ROWS+1.
//  Address arithmetic: 32-bit modulo 2^32, wrap silently; stride 0 legal (all rows same address).
//  mem_ack while mem_req=0 ignored. mem_addr/mem_wdata stable while mem_req held without ack.
// CONFIGURATION
//  MLS_ALIGN_CHECK_EN defined: on accept, if address or stride not multiple of ROW_W/8, go straight
//   to DONE with resp_err=1; no mem_req, no mrf_wen. Undefined: no check, resp_err=0, addresses
//   passed unmodified.
// STRUCTURE
//  datapath_pkg additions: MLS_ROWS/MLS_ROW_W constants, mls_resp_state_e {MLS_IDLE,MLS_LOAD,
//   MLS_STORE,MLS_DONE}. Sub-module mls_addr_gen: base/stride latch + accumulator, row counter, last flag.
// TESTING
//  Load, address=0x1000, stride=0x40, rd=5, mem_ack=1 -> addrs 0x1000/1040/1080/10C0, mrf rows 0..3 of
//   reg 5 written, resp_done=1 with resp_md=5 exactly 5 cycles after accept.
//  Store, rd=2, stride=0, ack delayed 3 cycles per row -> 4 writes at same address, mem_wdata=row r of
//   reg 2, addr/data stable during wait, single done pulse.
//  Second request held during busy -> req_ready=0 until IDLE; accepted cycle after DONE, no loss.
//  address=0xFFFFFFC0, stride=0x40 -> rows at 0xFFFFFFC0, 0x0, 0x40, 0x80 (wrap).
//  nRST low during row 2 of load -> all outputs 0 immediately, no done, next request runs cleanly.
//  MLS_ALIGN_CHECK_EN, address=0x1004 -> resp_done & resp_err next cycle, zero mem_req/mrf_wen.

Source files
------------

// File: rtl/scratchpad_mls_responder_pkg.sv
// rtl/scratchpad_mls_responder_pkg.sv - shared types and constants for the MLS scratchpad responder
package scratchpad_mls_responder_pkg;

  localparam int MLS_ROWS       = 4;
  localparam int MLS_ELEM_W     = 16;
  localparam int MLS_ROW_W      = MLS_ROWS * MLS_ELEM_W;
  localparam int MLS_ROW_IDX_W  = $clog2(MLS_ROWS);
  localparam int MLS_ALIGN_BITS = $clog2(MLS_ROW_W / 8);

  typedef logic [3:0] matbits_t;

  typedef enum logic [1:0] {
    MATRIX_NA = 2'd0,
    M_LOAD    = 2'd1,
    M_STORE   = 2'd2
  } matrix_ls_e;

  typedef struct packed {
    logic        done;
    matrix_ls_e  ls_out;
    matbits_t    rd_out;
    logic [31:0] address;
    logic [31:0] stride_out;
  } matrix_ls_t;

  typedef enum logic [1:0] {
    MLS_IDLE,
    MLS_LOAD,
    MLS_STORE,
    MLS_DONE
  } mls_resp_state_e;

endpackage

// File: rtl/scratchpad_mls_responder_if.sv
// rtl/scratchpad_mls_responder_if.sv - request, memory, regfile and response bundle of the MLS responder
interface scratchpad_mls_responder_if;
  import scratchpad_mls_responder_pkg::*;

  matrix_ls_t                mls_req;
  logic                      req_ready;
  logic                      mem_req;
  logic                      mem_wen;
  logic [31:0]               mem_addr;
  logic [MLS_ROW_W-1:0]      mem_wdata;
  logic [MLS_ROW_W-1:0]      mem_rdata;
  logic                      mem_ack;
  logic                      mrf_wen;
  matbits_t                  mrf_sel;
  logic [MLS_ROW_IDX_W-1:0]  mrf_row;
  logic [MLS_ROW_W-1:0]      mrf_wdata;
  logic [MLS_ROW_W-1:0]      mrf_rdata;
  logic                      resp_done;
  matbits_t                  resp_md;
  logic                      resp_err;

  modport slave (
    input  mls_req, mem_rdata, mem_ack, mrf_rdata,
    output req_ready, mem_req, mem_wen, mem_addr, mem_wdata,
           mrf_wen, mrf_sel, mrf_row, mrf_wdata, resp_done, resp_md, resp_err
  );

  modport master (
    output mls_req, mem_rdata, mem_ack, mrf_rdata,
    input  req_ready, mem_req, mem_wen, mem_addr, mem_wdata,
           mrf_wen, mrf_sel, mrf_row, mrf_wdata, resp_done, resp_md, resp_err
  );

endinterface

// File: rtl/scratchpad_mls_responder_addr_gen.sv
// rtl/scratchpad_mls_responder_addr_gen.sv - row address accumulator and row counter
module scratchpad_mls_responder_addr_gen
  import scratchpad_mls_responder_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_step,
  input  logic [31:0]              i_base,
  input  logic [31:0]              i_stride,
  output logic [31:0]              o_addr,
  output logic [MLS_ROW_IDX_W-1:0] o_row,
  output logic                     o_last
);

  logic [31:0]              r_addr;
  logic [31:0]              r_stride;
  logic [MLS_ROW_IDX_W-1:0] r_row;

  // Address wraps modulo 2^32; stride 0 keeps every row on the same address.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr   <= '0;
      r_stride <= '0;
      r_row    <= '0;
    end else if (i_start) begin
      r_addr   <= i_base;
      r_stride <= i_stride;
      r_row    <= '0;
    end else if (i_step) begin
      r_addr   <= r_addr + r_stride;
      r_row    <= r_row + 1'b1;
    end
  end

  assign o_addr = r_addr;
  assign o_row  = r_row;
  assign o_last = (r_row == MLS_ROW_IDX_W'(MLS_ROWS - 1));

endmodule

// File: rtl/scratchpad_mls_responder.sv
// rtl/scratchpad_mls_responder.sv - moves one matrix between memory and the matrix regfile per request
// Optional MLS_ALIGN_CHECK_EN: misaligned address/stride completes immediately with resp_err.
module scratchpad_mls_responder
  import scratchpad_mls_responder_pkg::*;
(
  input  logic                        i_clk,
  input  logic                        i_nrst,
  scratchpad_mls_responder_if.slave   io_mls
);

  mls_resp_state_e          r_state;
  mls_resp_state_e          w_state_nxt;
  matbits_t                 r_rd;
  logic                     r_err;
  logic                     w_valid;
  logic                     w_misaligned;
  logic                     w_start;
  logic                     w_step;
  logic                     w_last;
  logic [31:0]              w_addr;
  logic [MLS_ROW_IDX_W-1:0] w_row;

  assign w_valid = (io_mls.mls_req.ls_out != MATRIX_NA);

`ifdef MLS_ALIGN_CHECK_EN
  assign w_misaligned = (|io_mls.mls_req.address[MLS_ALIGN_BITS-1:0]) |
                        (|io_mls.mls_req.stride_out[MLS_ALIGN_BITS-1:0]);
`else
  assign w_misaligned = 1'b0;
`endif

  scratchpad_mls_responder_addr_gen u_addr_gen (
    .i_clk    (i_clk),
    .i_rst_n  (i_nrst),
    .i_start  (w_start),
    .i_step   (w_step),
    .i_base   (io_mls.mls_req.address),
    .i_stride (io_mls.mls_req.stride_out),
    .o_addr   (w_addr),
    .o_row    (w_row),
    .o_last   (w_last)
  );

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state <= MLS_IDLE;
      r_rd    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_rd  <= io_mls.mls_req.rd_out;
        r_err <= w_misaligned;
      end
    end
  end

  assign io_mls.mrf_sel = r_rd;
  assign io_mls.mrf_row = w_row;

  always_comb begin
    w_state_nxt      = r_state;
    w_start          = 1'b0;
    w_step           = 1'b0;
    io_mls.req_ready = 1'b0;
    io_mls.mem_req   = 1'b0;
    io_mls.mem_wen   = 1'b0;
    io_mls.mem_addr  = '0;
    io_mls.mem_wdata = '0;
    io_mls.mrf_wen   = 1'b0;
    io_mls.mrf_wdata = '0;
    io_mls.resp_done = 1'b0;
    io_mls.resp_md   = '0;
    io_mls.resp_err  = 1'b0;
    case (r_state)
      MLS_IDLE: begin
        // Ready is masked while reset is asserted so every output reads 0 in reset.
        io_mls.req_ready = i_nrst;
        if (w_valid) begin
          w_start = 1'b1;
          if (w_misaligned)                           w_state_nxt = MLS_DONE;
          else if (io_mls.mls_req.ls_out == M_LOAD)   w_state_nxt = MLS_LOAD;
          else                                        w_state_nxt = MLS_STORE;
        end
      end
      MLS_LOAD: begin
        io_mls.mem_req  = 1'b1;
        io_mls.mem_addr = w_addr;
        if (io_mls.mem_ack) begin
          io_mls.mrf_wen   = 1'b1;
          io_mls.mrf_wdata = io_mls.mem_rdata;
          w_step           = 1'b1;
          if (w_last) w_state_nxt = MLS_DONE;
        end
      end
      MLS_STORE: begin
        io_mls.mem_req   = 1'b1;
        io_mls.mem_wen   = 1'b1;
        io_mls.mem_addr  = w_addr;
        io_mls.mem_wdata = io_mls.mrf_rdata;
        if (io_mls.mem_ack) begin
          w_step = 1'b1;
          if (w_last) w_state_nxt = MLS_DONE;
        end
      end
      MLS_DONE: begin
        io_mls.resp_done = 1'b1;
        io_mls.resp_md   = r_rd;
        io_mls.resp_err  = r_err;
        w_state_nxt      = MLS_IDLE;
      end
      default: w_state_nxt = MLS_IDLE;
    endcase
  end

endmodule

// File: tb/tb_scratchpad_mls_responder.sv
// tb/tb_scratchpad_mls_responder.sv - table-driven bench for scratchpad_mls_responder
module tb_scratchpad_mls_responder;
  import scratchpad_mls_responder_pkg::*;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  scratchpad_mls_responder_if bus();

  scratchpad_mls_responder dut (
    .i_clk  (clk),
    .i_nrst (nrst),
    .io_mls (bus)
  );

  typedef struct {
    matrix_ls_e        ls;
    matbits_t          rd;
    logic [31:0]       addr;
    logic [31:0]       stride;
    int                delay;
    logic [3:0][31:0]  ea;
    int                elat;
  } vec_t;

  typedef struct { logic [31:0] addr; logic wen; logic [63:0] wdata; } acc_t;
  typedef struct { matbits_t sel; logic [1:0] row; logic [63:0] data; } mrfw_t;
  typedef struct { matbits_t md; logic err; int cyc; } done_t;

  acc_t  acc_q[$];
  mrfw_t mrf_q[$];
  done_t done_q[$];
  vec_t  vt[4];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int ack_delay = 0;
  int wait_cnt;
  int stab_err = 0;
  logic        p_pend = 1'b0;
  logic [31:0] p_addr;
  logic [63:0] p_wdata;

  function automatic logic [63:0] mrf_val(matbits_t s, logic [1:0] r);
    return {16'hC0DE, 12'h000, s, 30'h0, r};
  endfunction

  function automatic matrix_ls_t mk_req(matrix_ls_e ls, matbits_t rd, logic [31:0] a, logic [31:0] s);
    matrix_ls_t q;
    q.done = 1'b0; q.ls_out = ls; q.rd_out = rd; q.address = a; q.stride_out = s;
    return q;
  endfunction

  function automatic vec_t mk_vec(matrix_ls_e ls, matbits_t rd, logic [31:0] a, logic [31:0] s, int d,
                                  logic [31:0] e0, logic [31:0] e1, logic [31:0] e2, logic [31:0] e3, int lat);
    vec_t v;
    v.ls = ls; v.rd = rd; v.addr = a; v.stride = s; v.delay = d;
    v.ea[0] = e0; v.ea[1] = e1; v.ea[2] = e2; v.ea[3] = e3; v.elat = lat;
    return v;
  endfunction

  // Memory and regfile models
  always_comb bus.mem_rdata = {~bus.mem_addr, bus.mem_addr};
  always_comb bus.mrf_rdata = mrf_val(bus.mrf_sel, bus.mrf_row);
  always_comb bus.mem_ack = (ack_delay == 0) ? 1'b1 : (bus.mem_req && (wait_cnt == ack_delay));

  always @(posedge clk or negedge nrst) begin
    if (!nrst) wait_cnt <= 0;
    else if (bus.mem_req && !bus.mem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!nrst) begin
      p_pend = 1'b0;
    end else begin
      if (p_pend && bus.mem_req && (bus.mem_addr !== p_addr || bus.mem_wdata !== p_wdata)) stab_err++;
      if (bus.mem_req && bus.mem_ack) acc_q.push_back('{bus.mem_addr, bus.mem_wen, bus.mem_wdata});
      if (bus.mrf_wen) mrf_q.push_back('{bus.mrf_sel, bus.mrf_row, bus.mrf_wdata});
      if (bus.resp_done) done_q.push_back('{bus.resp_md, bus.resp_err, cyc});
      p_pend  = bus.mem_req && !bus.mem_ack;
      p_addr  = bus.mem_addr;
      p_wdata = bus.mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    acc_q.delete(); mrf_q.delete(); done_q.delete(); stab_err = 0;
  endtask

  task automatic wait_ready(output int k);
    k = -1;
    for (int i = 0; i < 100; i++) begin
      if (bus.req_ready) begin k = cyc; break; end
      @(negedge clk);
    end
    if (k < 0) chk("ready_timeout", bus.req_ready, 1);
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (done_q.size() >= n) break;
    end
    if (done_q.size() < n) chk("done_timeout", done_q.size(), n);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int k;
    clear_logs();
    ack_delay = v.delay;
    @(negedge clk);
    bus.mls_req = mk_req(v.ls, v.rd, v.addr, v.stride);
    wait_ready(k);
    @(negedge clk);
    bus.mls_req = '0;
    wait_done(1);
    chk($sformatf("v%0d_acc_n", id), acc_q.size(), 4);
    for (int r = 0; r < 4; r++) begin
      if (r < acc_q.size()) begin
        chk($sformatf("v%0d_addr%0d", id, r), acc_q[r].addr, v.ea[r]);
        chk($sformatf("v%0d_wen%0d", id, r), acc_q[r].wen, (v.ls == M_STORE));
        if (v.ls == M_STORE) chk($sformatf("v%0d_wdata%0d", id, r), acc_q[r].wdata, mrf_val(v.rd, 2'(r)));
      end
    end
    if (v.ls == M_LOAD) begin
      chk($sformatf("v%0d_mrf_n", id), mrf_q.size(), 4);
      for (int r = 0; r < 4; r++) begin
        if (r < mrf_q.size()) begin
          chk($sformatf("v%0d_mrf_sel%0d", id, r), mrf_q[r].sel, v.rd);
          chk($sformatf("v%0d_mrf_row%0d", id, r), mrf_q[r].row, r);
          chk($sformatf("v%0d_mrf_data%0d", id, r), mrf_q[r].data, {~v.ea[r], v.ea[r]});
        end
      end
    end else begin
      chk($sformatf("v%0d_mrf_n", id), mrf_q.size(), 0);
    end
    chk($sformatf("v%0d_done_n", id), done_q.size(), 1);
    if (done_q.size() > 0) begin
      chk($sformatf("v%0d_md", id), done_q[0].md, v.rd);
      chk($sformatf("v%0d_err", id), done_q[0].err, 0);
      chk($sformatf("v%0d_latency", id), done_q[0].cyc - k, v.elat);
    end
    chk($sformatf("v%0d_stable", id), stab_err, 0);
  endtask

  initial begin
    int k1;
    int k2;
    bus.mls_req = '0;
    vt[0] = mk_vec(M_LOAD,  4'd5, 32'h0000_1000, 32'h40,  0, 32'h1000, 32'h1040, 32'h1080, 32'h10C0, 5);
    vt[1] = mk_vec(M_STORE, 4'd2, 32'h0000_3000, 32'h0,   3, 32'h3000, 32'h3000, 32'h3000, 32'h3000, 17);
    vt[2] = mk_vec(M_LOAD,  4'd9, 32'hFFFF_FFC0, 32'h40,  0, 32'hFFFFFFC0, 32'h0, 32'h40, 32'h80, 5);
    vt[3] = mk_vec(M_STORE, 4'd7, 32'h0000_2000, 32'h100, 1, 32'h2000, 32'h2100, 32'h2200, 32'h2300, 9);

    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mrf_wen", bus.mrf_wen, 0);
    chk("rst_mrf_sel", bus.mrf_sel, 0);
    chk("rst_mrf_row", bus.mrf_row, 0);
    chk("rst_resp_done", bus.resp_done, 0);
    chk("rst_resp_err", bus.resp_err, 0);
    @(negedge clk);
    nrst = 1'b1;
    #1;
    chk("idle_req_ready", bus.req_ready, 1);

    for (int i = 0; i < 4; i++) run_vec(vt[i], i);

    // Second request held by the FU while the first is in flight
    clear_logs();
    ack_delay = 0;
    @(negedge clk);
    bus.mls_req = mk_req(M_LOAD, 4'd1, 32'h4000, 32'h8);
    wait_ready(k1);
    @(negedge clk);
    bus.mls_req = mk_req(M_STORE, 4'd6, 32'h5000, 32'h8);
    wait_ready(k2);
    chk("held_ready_cycle", k2 - k1, 6);
    chk("held_done1_n", done_q.size(), 1);
    if (done_q.size() > 0) chk("held_done1_md", done_q[0].md, 1);
    @(negedge clk);
    bus.mls_req = '0;
    wait_done(2);
    chk("held_done_n", done_q.size(), 2);
    if (done_q.size() > 1) begin
      chk("held_done2_md", done_q[1].md, 6);
      chk("held_done2_latency", done_q[1].cyc - k2, 5);
    end
    chk("held_acc_n", acc_q.size(), 8);
    if (acc_q.size() > 4) begin
      chk("held_acc4_addr", acc_q[4].addr, 32'h5000);
      chk("held_acc4_wen", acc_q[4].wen, 1);
    end

    // Reset asserted during row 2 of a load
    clear_logs();
    ack_delay = 2;
    @(negedge clk);
    bus.mls_req = mk_req(M_LOAD, 4'd3, 32'h500, 32'h10);
    wait_ready(k1);
    @(negedge clk);
    bus.mls_req = '0;
    for (int i = 0; i < 100; i++) begin
      if (mrf_q.size() >= 2) break;
      @(negedge clk); #1;
    end
    chk("rstmid_rows_before", mrf_q.size(), 2);
    @(negedge clk);
    #1;
    nrst = 1'b0;
    #1;
    chk("rstmid_mem_req", bus.mem_req, 0);
    chk("rstmid_mem_addr", bus.mem_addr, 0);
    chk("rstmid_mrf_row", bus.mrf_row, 0);
    chk("rstmid_mrf_sel", bus.mrf_sel, 0);
    chk("rstmid_req_ready", bus.req_ready, 0);
    chk("rstmid_resp_done", bus.resp_done, 0);
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    chk("rstmid_no_done", done_q.size(), 0);
    chk("rstmid_mrf_n", mrf_q.size(), 2);
    run_vec(vt[0], 9);

`ifdef MLS_ALIGN_CHECK_EN
    clear_logs();
    ack_delay = 0;
    @(negedge clk);
    bus.mls_req = mk_req(M_LOAD, 4'd4, 32'h1004, 32'h40);
    wait_ready(k1);
    @(negedge clk);
    bus.mls_req = '0;
    wait_done(1);
    chk("align_done_n", done_q.size(), 1);
    if (done_q.size() > 0) begin
      chk("align_latency", done_q[0].cyc - k1, 1);
      chk("align_err", done_q[0].err, 1);
      chk("align_md", done_q[0].md, 4);
    end
    chk("align_acc_n", acc_q.size(), 0);
    chk("align_mrf_n", mrf_q.size(), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
